// File: rtl/crop_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of a streaming crop engine.
// A grant is held for one full IN_ROWS*IN_COLS frame, then rotates to the next requester.
module crop_frame_arbiter #(
    parameter int PIXEL_BIT_WIDTH = 8,
    parameter int IN_ROWS         = 9,
    parameter int IN_COLS         = 9,
    parameter int NUM_REQ         = 4,
    localparam int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ*PIXEL_BIT_WIDTH-1:0] req_pixel,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [PIXEL_BIT_WIDTH-1:0]         pixel_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [GW-1:0]                      grant_id,
    output logic                               frame_active,
    output logic                               frame_done
);

    localparam int FRAME_PIX = IN_ROWS * IN_COLS;
    localparam int CW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIX - 1);
    localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic            hit_s;
    logic [GW-1:0]   hit_idx_s;
    logic            hs_s;

    // Round-robin search starting one past the most recent grantee.
    always_comb begin
        int idx;
        idx       = 0;
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!hit_s && req_valid[idx]) begin
                hit_s     = 1'b1;
                hit_idx_s = GW'(idx);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Zero-latency passthrough for the locked grantee; everything is quiet in IDLE.
    always_comb begin
        pixel_out = '0;
        out_valid = 1'b0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if ((state_q == BUSY) && (grant_q == GW'(k))) begin
                pixel_out    = req_pixel[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
                out_valid    = req_valid[k];
                req_ready[k] = out_ready;
            end else begin
                req_ready[k] = 1'b0;
            end
        end
    end

    assign hs_s = (state_q == BUSY) && out_valid && out_ready;

    // Next-state: grant on a hit in IDLE, release after the last pixel of the frame.
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        grant_d   = grant_q;
        last_d    = last_q;
        active_d  = active_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit_s) begin
                    state_d  = BUSY;
                    grant_d  = hit_idx_s;
                    last_d   = hit_idx_s;
                    active_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            BUSY: begin
                if (hs_s && (pix_cnt_q == LAST_PIX)) begin
                    state_d   = IDLE;
                    pix_cnt_d = '0;
                    active_d  = 1'b0;
                    done_d    = 1'b1;
                end else if (hs_s) begin
                    pix_cnt_d = pix_cnt_q + CW'(1);
                end else begin
                    pix_cnt_d = pix_cnt_q;
                end
            end
            default: begin
                state_d   = IDLE;
                pix_cnt_d = '0;
                active_d  = 1'b0;
            end
        endcase
    end

    // State and status registers; reset drops any partial frame without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pix_cnt_q <= '0;
            grant_q   <= '0;
            last_q    <= LAST_REQ;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign grant_id     = grant_q;
    assign frame_active = active_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_crop_frame_arbiter.sv
// Randomized and directed bench for crop_frame_arbiter with a frame-level reference model
// feeding a handshake scoreboard that a separate monitor drains.
module tb_crop_frame_arbiter;

    localparam int W     = 8;
    localparam int R     = 9;
    localparam int C     = 9;
    localparam int N     = 4;
    localparam int GW    = 2;
    localparam int FRAME = R * C;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*W-1:0]    req_pixel;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [W-1:0]      pixel_out;
    logic              out_valid;
    logic              out_ready;
    logic [GW-1:0]     grant_id;
    logic              frame_active;
    logic              frame_done;

    crop_frame_arbiter #(
        .PIXEL_BIT_WIDTH(W), .IN_ROWS(R), .IN_COLS(C), .NUM_REQ(N)
    ) dut (
        .clk(clk), .reset(reset), .req_pixel(req_pixel), .req_valid(req_valid),
        .req_ready(req_ready), .pixel_out(pixel_out), .out_valid(out_valid),
        .out_ready(out_ready), .grant_id(grant_id), .frame_active(frame_active),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // stimulus controls, applied by the driver one time unit after each rising edge
    logic          dir_reset = 1'b1;
    logic [N-1:0]  dir_valid = '0;
    logic          dir_ready = 1'b0;
    bit            rand_mode = 1'b0;

    // reference model state (state for the current cycle is snapshotted into s_*)
    bit m_busy, m_done_next;
    int m_g, m_gid, m_last, m_cnt, k_idx;
    bit m_found;
    bit s_busy, s_done;
    int s_g, s_gid;

    typedef struct { int g; logic [W-1:0] pix; } hs_t;
    hs_t exp_q[$];
    hs_t e;
    int  obs_grants[$];
    int  frames_seen = 0;
    int  hs_in_frame = 0;
    bit  prev_active = 1'b0;
    logic [N-1:0] exp_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // driver
    initial begin
        reset = 1'b1; req_valid = '0; out_ready = 1'b0; req_pixel = '0;
        forever begin
            @(posedge clk); #1;
            reset     = dir_reset;
            req_pixel = $urandom;
            if (rand_mode) begin
                req_valid = N'($urandom);
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                req_valid = dir_valid;
                out_ready = dir_ready;
            end
        end
    end

    // reference model: frame-level round robin computed from the inputs alone
    initial begin
        m_busy = 0; m_done_next = 0; m_g = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            s_busy = m_busy; s_g = m_g; s_gid = m_gid; s_done = m_done_next;
            m_done_next = 0;
            if (reset) begin
                m_busy = 0; m_g = 0; m_gid = 0; m_last = N - 1; m_cnt = 0;
                exp_q.delete();
            end else if (m_busy) begin
                if (req_valid[m_g] && out_ready) begin
                    exp_q.push_back('{m_g, req_pixel[m_g*W +: W]});
                    m_cnt++;
                    if (m_cnt == FRAME) begin
                        m_busy = 0; m_cnt = 0; m_done_next = 1;
                    end
                end
            end else begin
                m_found = 0;
                for (int i = 1; i <= N; i++) begin
                    k_idx = (m_last + i) % N;
                    if (!m_found && req_valid[k_idx]) begin
                        m_found = 1; m_busy = 1; m_g = k_idx; m_gid = k_idx; m_last = k_idx;
                    end
                end
            end
        end
    end

    // monitor: compares DUT outputs every cycle and drains the handshake scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                hs_in_frame = 0;
                prev_active = 1'b0;
            end else begin
                chk("frame_active", 64'(frame_active), 64'(s_busy));
                chk("frame_done", 64'(frame_done), 64'(s_done));
                chk("grant_id", 64'(grant_id), 64'(s_gid));
                chk("out_valid", 64'(out_valid), s_busy ? 64'(req_valid[s_g]) : 64'd0);
                exp_rdy = '0;
                if (s_busy) exp_rdy[s_g] = out_ready;
                chk("req_ready", 64'(req_ready), 64'(exp_rdy));
                if (!s_busy) chk("idle_pixel", 64'(pixel_out), 64'd0);
                if (out_valid && out_ready) begin
                    hs_in_frame++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_handshake", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hs_grant", 64'(grant_id), 64'(e.g));
                        chk("hs_pixel", 64'(pixel_out), 64'(e.pix));
                    end
                end
                if (frame_done) begin
                    chk("frame_len", 64'(hs_in_frame), 64'(FRAME));
                    frames_seen++;
                    hs_in_frame = 0;
                end
                if (frame_active && !prev_active) obs_grants.push_back(int'(grant_id));
                prev_active = frame_active;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset();
        dir_reset = 1'b1; dir_valid = '0; dir_ready = 1'b0;
        cycles(3);
        chk("rst_active", 64'(frame_active), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        dir_reset = 1'b0;
        frames_seen = 0;
        obs_grants.delete();
    endtask

    task automatic wait_frames(input int target, input int limit);
        int t;
        t = 0;
        while (frames_seen < target && t < limit) begin cycles(1); t++; end
        chk("frames_timeout", 64'(frames_seen >= target), 64'd1);
    endtask

    task automatic wait_hs(input int target, input int limit);
        int t;
        t = 0;
        while (hs_in_frame < target && t < limit) begin cycles(1); t++; end
        chk("hs_timeout", 64'(hs_in_frame >= target), 64'd1);
    endtask

    task automatic chk_grants(input int exp[$]);
        chk("grant_count", 64'(obs_grants.size() >= exp.size()), 64'd1);
        for (int i = 0; i < exp.size() && i < obs_grants.size(); i++)
            chk("grant_seq", 64'(obs_grants[i]), 64'(exp[i]));
    endtask

    initial begin
        // single source continuous
        do_reset();
        dir_valid = 4'b0100; dir_ready = 1'b1;
        wait_frames(2, 400);
        chk_grants('{2, 2});

        // all four contending
        do_reset();
        dir_valid = 4'b1111; dir_ready = 1'b1;
        wait_frames(5, 600);
        chk_grants('{0, 1, 2, 3, 0});

        // no preemption, then round-robin skip between 1 and 3
        do_reset();
        dir_valid = 4'b1010; dir_ready = 1'b1;
        wait_hs(40, 200);
        dir_valid = 4'b1000;
        cycles(5);
        chk("drop_grant", 64'(grant_id), 64'd1);
        chk("drop_valid", 64'(out_valid), 64'd0);
        chk("drop_active", 64'(frame_active), 64'd1);
        cycles(15);
        dir_valid = 4'b1010;
        wait_frames(4, 1000);
        chk_grants('{1, 3, 1, 3});

        // reset mid-frame
        do_reset();
        dir_valid = 4'b0100; dir_ready = 1'b1;
        wait_hs(30, 200);
        dir_reset = 1'b1; dir_valid = '0; dir_ready = 1'b0;
        cycles(2);
        chk("midrst_active", 64'(frame_active), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        chk("midrst_done", 64'(frame_done), 64'd0);
        chk("midrst_frames", 64'(frames_seen), 64'd0);
        dir_reset = 1'b0; dir_valid = 4'b1111; dir_ready = 1'b1;
        obs_grants.delete();
        wait_frames(1, 300);
        chk_grants('{0});

        // random backpressure on all requesters
        do_reset();
        rand_mode = 1'b1;
        wait_frames(120, 60000);
        rand_mode = 1'b0;
        dir_valid = '0; dir_ready = 1'b1;
        cycles(5);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
